ring_count_decoder: RTL and testbench

Receive-side companion to the team's ring counter. Samples a rotating one-hot ring code, converts it to a binary index, and checks that it is legal one-hot and advances by exactly one left-rotation per valid sample. An acquisition FSM declares lock after consecutive correct transitions, flags code and sequence errors, and keeps a saturating error count for status readback.

---
 rtl/ring_pkg.sv | 45 ++++
 rtl/ring_onehot_enc.sv | 34 +++
 rtl/ring_count_decoder.sv | 160 ++++++++++++++++
 tb/tb_ring_count_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared definitions for ring-code consumers: the acquisition FSM state
// type, index width helper, left-rotation and one-hot legality helpers.
// Helpers work on a fixed maximum width so that any ring width up to
// RING_MAX_WID can use them; callers zero-extend their codes.
// ---------------------------------------------------------------------------
package ring_pkg;

    // Acquisition FSM states
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_t;

    localparam int RING_MAX_WID = 64;

    // Index width for a ring of 'wid' bits, never less than one bit
    function automatic int idx_width(input int wid);
        return (wid <= 2) ? 1 : $clog2(wid);
    endfunction

    // Rotate the low 'wid' bits of v left by one; bits above wid stay zero
    function automatic logic [RING_MAX_WID-1:0] rotl(
        input logic [RING_MAX_WID-1:0] v,
        input int                      wid
    );
        logic [RING_MAX_WID-1:0] r;
        r    = '0;
        r[0] = v[wid-1];
        for (int i = 1; i < RING_MAX_WID; i++) begin
            if (i < wid) begin
                r[i] = v[i-1];
            end
        end
        return r;
    endfunction

    // True when exactly one bit is set (zero and multi-hot are both false)
    function automatic logic onehot_ok(input logic [RING_MAX_WID-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// ---------------------------------------------------------------------------
// ring_onehot_enc
// Combinational classifier/encoder for a ring code.
// Ports:
//   code       in   DATA_WID  ring code
//   is_zero    out  1         code is all zeros (ring counter seed)
//   is_onehot  out  1         exactly one bit set
//   index      out  IDX_W     position of the set bit (highest set bit
//                             when the code is multi-hot, 0 when zero)
// ---------------------------------------------------------------------------
module ring_onehot_enc
    import ring_pkg::*;
#(
    parameter  int DATA_WID = 4,
    localparam int IDX_W    = idx_width(DATA_WID)
) (
    input  logic [DATA_WID-1:0] code,
    output logic                is_zero,
    output logic                is_onehot,
    output logic [IDX_W-1:0]    index
);

    always_comb begin
        is_zero   = (code == '0);
        is_onehot = onehot_ok(RING_MAX_WID'(code));
        index     = '0;
        for (int i = 0; i < DATA_WID; i++) begin
            if (code[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_count_decoder.sv
// ---------------------------------------------------------------------------
// ring_count_decoder
// Receive-side checker for a rotating one-hot ring code. Converts legal
// codes to a binary index, checks each valid sample is one left-rotation of
// the previous one, declares lock after LOCK_CNT correct transitions and
// keeps a saturating error count. All outputs are registered (latency 1).
// Ports:
//   clk         in   1            clock, rising edge
//   rst         in   1            asynchronous active-high reset
//   ring_valid  in   1            sample ring_code this cycle
//   ring_code   in   DATA_WID     ring code
//   clr_err     in   1            synchronous clear of err_count
//   idx         out  IDX_W        set-bit position of last legal code
//   idx_valid   out  1            pulse, idx updated
//   code_err    out  1            pulse, illegal code sampled
//   seq_err     out  1            pulse, legal code but wrong successor
//   locked      out  1            FSM is in LOCKED
//   err_count   out  ERR_CNT_WID  saturating error event count
// ---------------------------------------------------------------------------
module ring_count_decoder
    import ring_pkg::*;
#(
    parameter  int DATA_WID    = 4,
    parameter  int LOCK_CNT    = 3,
    parameter  int ERR_CNT_WID = 8,
    localparam int IDX_W       = idx_width(DATA_WID)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ring_valid,
    input  logic [DATA_WID-1:0]    ring_code,
    input  logic                   clr_err,
    output logic [IDX_W-1:0]       idx,
    output logic                   idx_valid,
    output logic                   code_err,
    output logic                   seq_err,
    output logic                   locked,
    output logic [ERR_CNT_WID-1:0] err_count
);

    // good_cnt must be able to hold LOCK_CNT itself
    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    ring_state_t         state;
    logic [DATA_WID-1:0] prev;
    logic [GOOD_W-1:0]   good_cnt;
    logic [GOOD_W-1:0]   good_inc;

    logic                is_zero;
    logic                is_legal;
    logic [IDX_W-1:0]    code_idx;
    logic                is_expected;
    logic                code_err_ev;
    logic                seq_err_ev;
    logic                any_err;

    ring_onehot_enc #(
        .DATA_WID (DATA_WID)
    ) u_enc (
        .code      (ring_code),
        .is_zero   (is_zero),
        .is_onehot (is_legal),
        .index     (code_idx)
    );

    // Classify this sample against the FSM state. A zero code is the
    // counter's seed and is only tolerated while searching.
    always_comb begin
        good_inc    = good_cnt + 1'b1;
        is_expected = is_legal &&
                      (RING_MAX_WID'(ring_code) == rotl(RING_MAX_WID'(prev), DATA_WID));
        code_err_ev = 1'b0;
        seq_err_ev  = 1'b0;
        if (ring_valid) begin
            if (state == SEARCH) begin
                code_err_ev = !is_zero && !is_legal;
            end else begin
                code_err_ev = !is_legal;
                seq_err_ev  = is_legal && !is_expected;
            end
        end
        any_err = code_err_ev || seq_err_ev;
    end

    // Acquisition FSM with its registered outputs and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            prev      <= '0;
            good_cnt  <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            idx_valid <= 1'b0;
            code_err  <= code_err_ev;
            seq_err   <= seq_err_ev;

            if (ring_valid && is_legal) begin
                idx       <= code_idx;
                idx_valid <= 1'b1;
            end

            if (ring_valid) begin
                case (state)
                    SEARCH: begin
                        if (is_legal) begin
                            state    <= ACQUIRE;
                            prev     <= ring_code;
                            good_cnt <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (is_expected) begin
                            prev     <= ring_code;
                            good_cnt <= good_inc;
                            if (good_inc == GOOD_W'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (is_legal) begin
                            prev     <= ring_code;
                            good_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        if (is_expected) begin
                            prev <= ring_code;
                        end else if (is_legal) begin
                            prev     <= ring_code;
                            good_cnt <= '0;
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                        end else begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end

            // A clear that coincides with an error still records that error
            if (clr_err) begin
                err_count <= any_err ? ERR_CNT_WID'(1) : '0;
            end else if (any_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_count_decoder.sv
// ---------------------------------------------------------------------------
// tb_ring_count_decoder
// Scoreboard bench: each driven cycle pushes the expected response from a
// position-based reference model; a monitor pops and compares one entry
// after every rising edge.
// ---------------------------------------------------------------------------
module tb_ring_count_decoder;

    localparam int DATA_WID    = 4;
    localparam int LOCK_CNT    = 3;
    localparam int ERR_CNT_WID = 8;
    localparam int IDX_W       = 2;
    localparam int ERR_MAX     = (1 << ERR_CNT_WID) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   ring_valid = 1'b0;
    logic [DATA_WID-1:0]    ring_code = '0;
    logic                   clr_err = 1'b0;
    logic [IDX_W-1:0]       idx;
    logic                   idx_valid;
    logic                   code_err;
    logic                   seq_err;
    logic                   locked;
    logic [ERR_CNT_WID-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int idx;
        int idx_valid;
        int code_err;
        int seq_err;
        int locked;
        int err_count;
    } resp_t;

    resp_t exp_q[$];

    // Reference model: mode 0 searching, 1 acquiring, 2 locked
    int m_mode     = 0;
    int m_streak   = 0;
    int m_prev_pos = 0;
    int m_idx      = 0;
    int m_cnt      = 0;

    ring_count_decoder #(
        .DATA_WID    (DATA_WID),
        .LOCK_CNT    (LOCK_CNT),
        .ERR_CNT_WID (ERR_CNT_WID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ring_valid (ring_valid),
        .ring_code  (ring_code),
        .clr_err    (clr_err),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .code_err   (code_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input resp_t e);
        checkField("idx",       int'(idx),       e.idx);
        checkField("idx_valid", int'(idx_valid), e.idx_valid);
        checkField("code_err",  int'(code_err),  e.code_err);
        checkField("seq_err",   int'(seq_err),   e.seq_err);
        checkField("locked",    int'(locked),    e.locked);
        checkField("err_count", int'(err_count), e.err_count);
    endtask

    function automatic int bitPos(input logic [DATA_WID-1:0] c);
        for (int i = 0; i < DATA_WID; i++) begin
            if (c[i]) return i;
        end
        return -1;
    endfunction

    // Advance the reference model by one cycle and return the response
    task automatic modelStep(input bit v, input logic [DATA_WID-1:0] code,
                             input bit clr, output resp_t e);
        int  ones;
        int  pos;
        bit  cerr;
        bit  serr;
        bit  ivld;
        ones = $countones(code);
        pos  = bitPos(code);
        cerr = 0;
        serr = 0;
        ivld = 0;
        if (v) begin
            if (ones == 1) begin
                m_idx = pos;
                ivld  = 1;
            end
            if (m_mode == 0) begin
                if (ones == 1) begin
                    m_mode     = 1;
                    m_prev_pos = pos;
                    m_streak   = 0;
                end else if (ones > 1) begin
                    cerr = 1;
                end
            end else if (ones != 1) begin
                cerr   = 1;
                m_mode = 0;
            end else if (pos == (m_prev_pos + 1) % DATA_WID) begin
                m_prev_pos = pos;
                if (m_mode == 1) begin
                    m_streak++;
                    if (m_streak == LOCK_CNT) m_mode = 2;
                end
            end else begin
                serr       = 1;
                m_prev_pos = pos;
                m_streak   = 0;
                m_mode     = 1;
            end
        end
        if (clr) begin
            m_cnt = (cerr || serr) ? 1 : 0;
        end else if (cerr || serr) begin
            m_cnt = (m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX;
        end
        e.idx       = m_idx;
        e.idx_valid = ivld;
        e.code_err  = cerr;
        e.seq_err   = serr;
        e.locked    = (m_mode == 2) ? 1 : 0;
        e.err_count = m_cnt;
    endtask

    task automatic applyStimulus(input bit v, input logic [DATA_WID-1:0] code, input bit clr);
        resp_t e;
        @(negedge clk);
        ring_valid = v;
        ring_code  = code;
        clr_err    = clr;
        modelStep(v, code, clr, e);
        exp_q.push_back(e);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge
    task automatic applyReset();
        @(negedge clk);
        ring_valid = 1'b0;
        clr_err    = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkField("rst_idx",       int'(idx),       0);
        checkField("rst_idx_valid", int'(idx_valid), 0);
        checkField("rst_code_err",  int'(code_err),  0);
        checkField("rst_seq_err",   int'(seq_err),   0);
        checkField("rst_locked",    int'(locked),    0);
        checkField("rst_err_count", int'(err_count), 0);
        exp_q.delete();
        m_mode     = 0;
        m_streak   = 0;
        m_prev_pos = 0;
        m_idx      = 0;
        m_cnt      = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one expected response per rising edge while entries exist
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [DATA_WID-1:0] c;
        int                  r;

        applyReset();

        // Seed, then one full rotation to lock
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(1, 4'b0010, 0);
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b1000, 0);
        // Wrap while locked
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(1, 4'b0010, 0);
        // Wrong successor drops lock, then relock
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(1, 4'b0010, 0);
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b1000, 0);
        // Multi-hot while locked, then seed in SEARCH
        applyStimulus(1, 4'b0011, 0);
        applyStimulus(1, 4'b0000, 0);
        // Relock, then gaps in ring_valid
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(1, 4'b0010, 0);
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b1000, 0);
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(0, 4'(3'($urandom)), 0);
        applyStimulus(1, 4'b0010, 0);
        applyStimulus(0, 4'(3'($urandom)), 0);

        // Saturate the error counter, then clear with a coincident error
        for (int i = 0; i < ERR_MAX + 3; i++) begin
            applyStimulus(1, 4'b0011, 0);
        end
        applyStimulus(1, 4'b1111, 1);
        applyStimulus(1, 4'b0000, 1);

        // Reset while locked; next legal code restarts acquisition
        applyStimulus(1, 4'b0001, 0);
        applyStimulus(1, 4'b0010, 0);
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b1000, 0);
        applyReset();
        applyStimulus(1, 4'b0100, 0);
        applyStimulus(1, 4'b1000, 0);

        // Randomised traffic biased toward correct successors
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4 && m_mode != 0) begin
                c = 4'(1 << ((m_prev_pos + 1) % DATA_WID));
            end else if (r == 5) begin
                c = '0;
            end else if (r <= 7) begin
                c = 4'(1 << $urandom_range(0, DATA_WID - 1));
            end else begin
                c = 4'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 99) < 85), c, ($urandom_range(0, 99) < 2));
        end

        @(negedge clk);
        ring_valid = 1'b0;
        clr_err    = 1'b0;
        repeat (3) @(negedge clk);
        checkField("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
